ps2_keyboard_tx: RTL and testbench
==================================

# ps2_keyboard_tx

Device-side PS/2 transmitter: a keyboard model that turns key events into PS/2 frames on `ps2_clk`/`ps2_data`. It generates the PS/2 clock itself and is the counterpart of the NPC PS/2 host receiver. Key events (scancode plus make/release flag) are queued in a small FIFO. Release events expand to the break prefix `0xF0` followed by the scancode. Each byte is serialized as start, 8 data bits LSB first, odd parity and stop, with a fixed idle gap between frames.

## Interface
Parameters:
- `CLK_HALF`, default 4: `clk` cycles per PS/2 clock half-period; must be ≥2.
- `GAP`, default 8: idle `clk` cycles between frames, with both lines high; must be ≥1.
- `DEPTH`, default 8: byte FIFO depth; must be a power of two, ≥4.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset; synchronous, active-high.
- `in_valid`, in, 1: key event offered.
- `in_ready`, out, 1: FIFO has ≥2 free slots.
- `in_code`, in, 8: scancode.
- `in_release`, in, 1: 1 = release event (emit `F0`, then code); 0 = make event (emit code only).
- `ps2_clk`, out, 1: PS/2 clock, idle high.
- `ps2_data`, out, 1: PS/2 data, idle high.
- `busy`, out, 1: frame or gap in progress, or FIFO non-empty.
- `tx_done`, out, 1: one-cycle pulse after the stop-bit low phase ends.

## Operation
- An event is accepted when `in_valid && in_ready` at a rising edge. Inputs are ignored while `reset` is high.
- `in_ready` is combinational: `free >= 2`. It is required even for make events, so both event kinds see one rule.
- Make event: push `in_code`. Release event: push `0xF0`, then `in_code`, in the same cycle (2-entry write).
- A push and a pop in the same cycle are legal; occupancy changes by pushes minus pops.
- FSM states: IDLE, HIGH, LOW, GAP.
  - IDLE: if the FIFO is non-empty, pop a byte and load an 11-bit shift frame `{1, ~^byte, byte, 0}` (bit 0 sent first). Go to HIGH.
  - HIGH: `ps2_clk`=1, `ps2_data` = current frame bit. Stay `CLK_HALF` cycles, then go to LOW.
  - LOW: `ps2_clk`=0, `ps2_data` holds. Stay `CLK_HALF` cycles. If the bit index is less than 10, advance the index and go to HIGH. After bit 10, pulse `tx_done`, drive both lines 1, and go to GAP.
  - GAP: both lines 1 for `GAP` cycles, then go to IDLE.
- `ps2_data` changes only at the start of HIGH, so it is stable at least `CLK_HALF` cycles before each falling edge of `ps2_clk` and through the whole LOW phase.
- Parity is odd: the parity bit is chosen so the count of ones in data plus parity is odd.
- FIFO order is strict; no byte is dropped or reordered.
- Reset values: `ps2_clk`=1, `ps2_data`=1, `busy`=0, `tx_done`=0, FIFO empty (so `in_ready`=1), FSM in IDLE, counters 0.
- Reset mid-frame aborts the frame: lines return to 1 on the next edge and the FIFO is flushed.

## Timing
- All outputs are registered except `in_ready`.
- Accept at edge N into an empty FIFO with the FSM in IDLE:
  - The byte is visible in the FIFO after edge N.
  - The FSM pops it at edge N+1.
  - `ps2_data`=0 (start bit) from edge N+2.
  - First `ps2_clk` falling edge at edge N+2+`CLK_HALF`.
- Frame length: 22·`CLK_HALF` cycles from start-bit drive to `tx_done`. Back-to-back frame period: 22·`CLK_HALF`+`GAP`+1 cycles.
- 11 falling edges per frame. The receiver samples bits 0–9 into its buffer and checks the stop bit on the 11th edge.

## Structure
- Shared package `ps2_pkg`: `PS2_BREAK = 8'hF0`, `PS2_FRAME_BITS = 11`, FSM state enum.
- Sub-module `ps2_tx_fifo`: synchronous FIFO, 8-bit wide, `DEPTH` entries. It has a 1- or 2-entry write port, a single read port, and `count` / `free` outputs. Pointers wrap modulo `DEPTH` with an extra MSB for full/empty detection.
- The top module holds the FSM, the phase counter (`$clog2(max(CLK_HALF,GAP))` bits), the 4-bit bit index and the shift register.

## Test plan
- Make `0x1C`, `CLK_HALF`=4: `ps2_data` sequence at falling edges is 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. `tx_done` fires once. Looped into the host receiver, it gives `key_data`=`0x61` with a one-cycle `valid`.
- Release `0x1C`: two frames in order, `F0` (bits 0,0,0,0,0,1,1,1,1, parity 1, stop 1) then `1C`. Frames are separated by exactly `GAP` idle cycles. The receiver goes START→END→IDLE with no `valid` for either byte.
- Parity sweep: codes `0x00` (parity 1), `0xFF` (parity 1), `0x01` (parity 0). Verify against the receiver's odd-parity check.
- Back-pressure, `DEPTH`=8: issue 10 consecutive make events with `in_valid` held. `in_ready` drops when `free`<2. Every accepted code is transmitted in order, and no push happens while `in_ready`=0.
- Assert `reset` during bit 5 of a frame with 3 bytes queued. The next cycle has `ps2_clk`=1, `ps2_data`=1, `busy`=0 and `in_ready`=1, and no further frames are emitted.
- Push in the same cycle the FSM pops from a FIFO holding 6 entries: occupancy becomes 6−1+1 = 6 and the order is preserved.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, transmitter FSM state type and frame builder.
// Latency: n/a (package). Backpressure: n/a.
// Contents: PS2_BREAK prefix, PS2_FRAME_BITS, ps2_state_e, ps2_frame().
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } ps2_state_e;

  // Frame word, bit 0 goes on the wire first: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_keyboard_tx_if.sv
// Key-event handshake bundle between an event source and the PS/2 transmitter.
// Latency: n/a (wires only). Backpressure: in_ready from the transmitter gates acceptance.
// Signals: in_valid, in_code[7:0], in_release (source -> tx), in_ready (tx -> source).
interface ps2_keyboard_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       in_release;

  modport master (output in_valid, output in_code, output in_release, input in_ready);
  modport slave  (input in_valid, input in_code, input in_release, output in_ready);
endinterface

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO with a 1- or 2-entry write port and a single read port.
// Latency: a written byte is readable (rd_dat, count) the cycle after the write edge.
// Backpressure: none internally; the writer must check free before writing.
// Ports: clk, reset, wr_en, wr_two, wr_dat0, wr_dat1, rd_en, rd_dat, count, free.
module ps2_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_two,
  input  logic [7:0]             wr_dat0,
  input  logic [7:0]             wr_dat1,
  input  logic                   rd_en,
  output logic [7:0]             rd_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] free
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] wptr_p1;

  // Pointers carry one extra MSB so full (count == DEPTH) differs from empty.
  assign wptr_p1 = wptr + (AW+1)'(1);
  assign count   = wptr - rptr;
  assign free    = DEPTH_W - count;
  assign rd_dat  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wptr[AW-1:0]] <= wr_dat0;
      if (wr_two) mem[wptr_p1[AW-1:0]] <= wr_dat1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wr_two ? (wptr + (AW+1)'(2)) : wptr_p1;
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: queues key events and serializes them as PS/2 frames.
// Latency: event accepted at edge N drives the start bit from edge N+2; frame is 22*CLK_HALF cycles.
// Backpressure: evt.in_ready is low unless the byte FIFO has at least two free slots.
// Ports: clk, reset, evt (key-event handshake), ps2_clk, ps2_data, busy, tx_done.
module ps2_keyboard_tx #(
  parameter int CLK_HALF = 4,
  parameter int GAP      = 8,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  ps2_keyboard_tx_if.slave         evt,
  output logic                     ps2_clk,
  output logic                     ps2_data,
  output logic                     busy,
  output logic                     tx_done
);
  import ps2_pkg::*;

  localparam int             CNT_MAX   = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int             CW        = $clog2(CNT_MAX);
  localparam int             AW        = $clog2(DEPTH);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP - 1);

  ps2_state_e                 state;
  ps2_state_e                 state_nxt;
  logic [CW-1:0]              cnt;
  logic [3:0]                 bit_idx;
  logic [PS2_FRAME_BITS-1:0]  shift;

  logic [7:0]  rd_dat;
  logic [AW:0] count;
  logic [AW:0] free;
  logic        push;
  logic        pop;
  logic        half_end;
  logic        gap_end;
  logic        last_bit;
  logic        clk_d;
  logic        data_d;
  logic        done_d;
  logic        busy_d;

  // Ready needs two slots even for make events so both event kinds obey one rule.
  assign evt.in_ready = (free >= (AW+1)'(2));
  assign push         = evt.in_valid && evt.in_ready;
  assign pop          = (state == ST_IDLE) && (count != '0);
  assign half_end     = (cnt == HALF_LAST);
  assign gap_end      = (cnt == GAP_LAST);
  assign last_bit     = (bit_idx == 4'(PS2_FRAME_BITS - 1));

  // Release events write the break prefix and the code in one cycle.
  ps2_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_two  (evt.in_release),
    .wr_dat0 (evt.in_release ? PS2_BREAK : evt.in_code),
    .wr_dat1 (evt.in_code),
    .rd_en   (pop),
    .rd_dat  (rd_dat),
    .count   (count),
    .free    (free)
  );

  // State register plus the phase counter, bit index and shift frame it sequences.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ps2_clk  <= clk_d;
      ps2_data <= data_d;
      busy     <= busy_d;
      tx_done  <= done_d;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift   <= ps2_frame(rd_dat);
            bit_idx <= '0;
            cnt     <= '0;
          end
        end
        ST_HIGH: cnt <= half_end ? '0 : cnt + CW'(1);
        ST_LOW: begin
          if (half_end) begin
            cnt <= '0;
            // Shifting only here means the data line changes only as HIGH begins.
            if (!last_bit) begin
              bit_idx <= bit_idx + 4'd1;
              shift   <= {1'b1, shift[PS2_FRAME_BITS-1:1]};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP:  cnt <= gap_end ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pop)      state_nxt = ST_HIGH;
      ST_HIGH: if (half_end) state_nxt = ST_LOW;
      ST_LOW:  if (half_end) state_nxt = last_bit ? ST_GAP : ST_HIGH;
      ST_GAP:  if (gap_end)  state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so the wire
  // trails the FSM by one cycle; tx_done marks the first GAP cycle.
  always_comb begin
    clk_d  = 1'b1;
    data_d = 1'b1;
    done_d = 1'b0;
    busy_d = (state != ST_IDLE) || (count != '0);
    case (state)
      ST_HIGH: data_d = shift[0];
      ST_LOW: begin
        clk_d  = 1'b0;
        data_d = shift[0];
      end
      ST_GAP:  done_d = (cnt == '0);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: table of key events with hand-computed frames,
// plus sequences for back-pressure, mid-frame reset and push-during-pop.
// A monitor samples ps2_data at every ps2_clk falling edge and rebuilds 11-bit frames.
module tb_ps2_keyboard_tx;

  logic clk;
  logic reset;
  logic ps2_clk;
  logic ps2_data;
  logic busy;
  logic tx_done;

  ps2_keyboard_tx_if kif ();

  ps2_keyboard_tx #(.CLK_HALF(4), .GAP(8), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .evt      (kif),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [10:0] frames_q [$];
  int          start_q  [$];
  int          fall_q   [$];
  int          done_q   [$];
  int          bitcnt   = 0;
  int          stab_err = 0;

  // Receiver-side monitor.
  initial begin
    logic        prev_clk;
    logic        prev_data;
    logic        low_data;
    logic [10:0] sh;
    prev_clk  = 1'b1;
    prev_data = 1'b1;
    low_data  = 1'b1;
    sh        = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bitcnt    = 0;
        prev_clk  = 1'b1;
        prev_data = 1'b1;
      end else begin
        if (prev_clk && !ps2_clk) begin
          if (bitcnt == 0) fall_q.push_back(cyc);
          sh[bitcnt] = ps2_data;
          low_data   = ps2_data;
          if (bitcnt == 10) begin
            frames_q.push_back(sh);
            bitcnt = 0;
          end else begin
            bitcnt = bitcnt + 1;
          end
        end else if (!ps2_clk && (ps2_data != low_data)) begin
          stab_err = stab_err + 1;
        end
        if (ps2_clk && prev_data && !ps2_data && bitcnt == 0) start_q.push_back(cyc);
        if (tx_done) done_q.push_back(cyc);
        prev_clk  = ps2_clk;
        prev_data = ps2_data;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic clear_mon();
    frames_q.delete();
    start_q.delete();
    fall_q.delete();
    done_q.delete();
  endtask

  // Offers one event, waiting (bounded) for in_ready; acc = edge index of acceptance.
  task automatic send(input logic rel, input logic [7:0] code, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!kif.in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("send ready", int'(t < 400), 1);
    kif.in_valid   = 1'b1;
    kif.in_code    = code;
    kif.in_release = rel;
    @(negedge clk);
    acc          = cyc;
    kif.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int t;
    t = 0;
    repeat (3) @(negedge clk);
    while (busy && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    chk({name, " idle"}, int'(t < max_cyc), 1);
  endtask

  typedef struct {
    logic        rel;
    logic [7:0]  code;
    int          n;
    logic [10:0] f0;
    logic [10:0] f1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          acc;
    int          t;
    int          tdone;
    int          acc_n;
    int          stalls;
    logic [7:0]  bp_codes [10];
    logic [7:0]  pp_codes [8];

    // Frame words, bit 0 first: {stop, parity, data[7:0], start}.
    vecs[0] = '{1'b0, 8'h1C, 1, 11'h438, 11'h000};
    vecs[1] = '{1'b1, 8'h1C, 2, 11'h7E0, 11'h438};
    vecs[2] = '{1'b0, 8'h00, 1, 11'h600, 11'h000};
    vecs[3] = '{1'b0, 8'hFF, 1, 11'h7FE, 11'h000};
    vecs[4] = '{1'b0, 8'h01, 1, 11'h402, 11'h000};
    vecs[5] = '{1'b1, 8'h5A, 2, 11'h7E0, 11'h6B4};

    reset          = 1'b1;
    kif.in_valid   = 1'b0;
    kif.in_code    = 8'h00;
    kif.in_release = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ps2_clk", int'(ps2_clk), 1);
    chk("rst ps2_data", int'(ps2_data), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst tx_done", int'(tx_done), 0);
    chk("rst in_ready", int'(kif.in_ready), 1);
    reset = 1'b0;

    // Table-driven single events.
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send(vecs[i].rel, vecs[i].code, acc);
      wait_idle(600, $sformatf("v%0d", i));
      chk($sformatf("v%0d frame count", i), frames_q.size(), vecs[i].n);
      chk($sformatf("v%0d tx_done count", i), done_q.size(), vecs[i].n);
      if (frames_q.size() > 0) chk($sformatf("v%0d frame0", i), int'(frames_q[0]), int'(vecs[i].f0));
      if (frames_q.size() > 1) chk($sformatf("v%0d frame1", i), int'(frames_q[1]), int'(vecs[i].f1));
      if (start_q.size() > 0) begin
        chk($sformatf("v%0d start latency", i), start_q[0] - acc, 2);
        if (fall_q.size() > 0) chk($sformatf("v%0d first fall", i), fall_q[0] - start_q[0], 4);
        if (done_q.size() > 0) chk($sformatf("v%0d frame length", i), done_q[0] - start_q[0], 88);
      end
      if (start_q.size() > 1) chk($sformatf("v%0d frame period", i), start_q[1] - start_q[0], 97);
    end

    // Back-pressure: in_valid held across 10 make events.
    clear_mon();
    for (int i = 0; i < 10; i++) bp_codes[i] = 8'h10 + 8'(i * 7);
    acc_n  = 0;
    stalls = 0;
    @(negedge clk);
    kif.in_valid   = 1'b1;
    kif.in_release = 1'b0;
    kif.in_code    = bp_codes[0];
    for (int c = 0; c < 3000 && acc_n < 10; c++) begin
      if (kif.in_ready) begin
        @(negedge clk);
        acc_n++;
        if (acc_n == 8) chk("bp ready low at 7 entries", int'(kif.in_ready), 0);
        if (acc_n < 10) kif.in_code = bp_codes[acc_n];
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    kif.in_valid = 1'b0;
    chk("bp accepted", acc_n, 10);
    chk("bp stalled", int'(stalls > 0), 1);
    wait_idle(2000, "bp");
    chk("bp frame count", frames_q.size(), 10);
    for (int i = 0; i < 10; i++)
      if (frames_q.size() > i) chk($sformatf("bp frame%0d", i), int'(frames_q[i]), int'(exp_frame(bp_codes[i])));

    // Reset during bit 5 with three bytes queued.
    clear_mon();
    send(1'b0, 8'h31, acc);
    send(1'b0, 8'h32, acc);
    send(1'b0, 8'h33, acc);
    send(1'b0, 8'h34, acc);
    t = 0;
    while (bitcnt != 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rst2 reached bit5", int'(t < 500), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2 ps2_clk", int'(ps2_clk), 1);
    chk("rst2 ps2_data", int'(ps2_data), 1);
    chk("rst2 busy", int'(busy), 0);
    chk("rst2 in_ready", int'(kif.in_ready), 1);
    reset = 1'b0;
    clear_mon();
    repeat (400) @(negedge clk);
    chk("rst2 no frames", frames_q.size(), 0);
    chk("rst2 no starts", start_q.size(), 0);
    chk("rst2 busy after", int'(busy), 0);

    // Push in the same cycle the FSM pops, with 6 entries queued.
    clear_mon();
    for (int i = 0; i < 8; i++) pp_codes[i] = 8'h41 + 8'(i);
    for (int i = 0; i < 7; i++) send(1'b0, pp_codes[i], acc);
    chk("pp ready at 6", int'(kif.in_ready), 1);
    t = 0;
    while (!tx_done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("pp tx_done seen", int'(t < 400), 1);
    tdone = cyc;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pp ready before", int'(kif.in_ready), 1);
    kif.in_valid   = 1'b1;
    kif.in_release = 1'b0;
    kif.in_code    = pp_codes[7];
    @(negedge clk);
    kif.in_valid = 1'b0;
    chk("pp ready after (6 entries)", int'(kif.in_ready), 1);
    wait_idle(1200, "pp");
    if (start_q.size() > 1) chk("pp pop edge", start_q[1] - tdone, 9);
    chk("pp frame count", frames_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (frames_q.size() > i) chk($sformatf("pp frame%0d", i), int'(frames_q[i]), int'(exp_frame(pp_codes[i])));

    chk("data stable while ps2_clk low", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
